// File: rtl/fsu4_pkg.sv
// fsu4_pkg: shared state encoding and sizing constants for the nibble-serial subtractor.
package fsu4_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} fsu4_state_t;
    localparam int NIB_W = 4;
    localparam int FSU4_WIDTH = 16;
endpackage

// File: rtl/fsu4_slice.sv
// fsu4_slice: combinational 4-bit subtract slice built as X + ~Y + ~BIN.
module fsu4_slice
    import fsu4_pkg::*;
(
    input  logic [NIB_W-1:0] X,
    input  logic [NIB_W-1:0] Y,
    input  logic             BIN,
    output logic [NIB_W-1:0] DIFF,
    output logic             BOUT
);
    logic [NIB_W:0] w_sum;
    assign w_sum = {1'b0, X} + {1'b0, ~Y} + {{NIB_W{1'b0}}, ~BIN};
    assign DIFF  = w_sum[NIB_W-1:0];
    assign BOUT  = ~w_sum[NIB_W];
endmodule

// File: rtl/fsu4_seq.sv
// fsu4_seq: sequential A - B - BI, one nibble per clock through a single shared slice.
module fsu4_seq
    import fsu4_pkg::*;
#(
    parameter int WIDTH = FSU4_WIDTH
) (
    input  logic             CK,
    input  logic             CD,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BI,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] D,
    output logic             BO,
    output logic             OV
);
    localparam int NNIB = WIDTH / NIB_W;
    localparam int IW   = (NNIB > 1) ? $clog2(NNIB) : 1;

    if (WIDTH < NIB_W || WIDTH % NIB_W != 0) begin : g_bad_width
        $error("fsu4_seq: WIDTH must be a positive multiple of 4");
    end

    fsu4_state_t      r_state, w_next;
    logic [IW-1:0]    r_idx;
    logic             r_borrow, r_bo, r_ov;
    logic [WIDTH-1:0] r_a, r_b, r_shadow, r_d;
    logic [WIDTH-1:0] w_shadow;
    logic [NIB_W-1:0] w_x, w_y, w_diff;
    logic             w_bout, w_last, w_accept;

    assign w_x      = NIB_W'(r_a >> {r_idx, 2'b00});
    assign w_y      = NIB_W'(r_b >> {r_idx, 2'b00});
    assign w_last   = r_idx == IW'(NNIB - 1);
    assign w_accept = (r_state == ST_IDLE) && START;
    // Nibbles enter at the top and shift down, so after NNIB steps nibble 0 sits at the bottom.
    assign w_shadow = (r_shadow >> NIB_W) | (WIDTH'(w_diff) << (WIDTH - NIB_W));

    fsu4_slice u_slice (
        .X    (w_x),
        .Y    (w_y),
        .BIN  (r_borrow),
        .DIFF (w_diff),
        .BOUT (w_bout)
    );

    always_ff @(posedge CK or posedge CD) begin
        if (CD) r_state <= ST_IDLE;
        else    r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_accept)                         w_next = ST_RUN;
        else if (r_state == ST_RUN && w_last) w_next = ST_DONE;
        else if (r_state == ST_DONE)          w_next = ST_IDLE;
    end

    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= '0;
            r_borrow <= 1'b0;
            r_shadow <= '0;
            r_d      <= '0;
            r_bo     <= 1'b0;
            r_ov     <= 1'b0;
        end else if (w_accept) begin
            r_a      <= A;
            r_b      <= B;
            r_idx    <= '0;
            r_borrow <= BI;
            r_shadow <= '0;
        end else if (r_state == ST_RUN) begin
            r_shadow <= w_shadow;
            r_borrow <= w_bout;
            r_idx    <= r_idx + 1'b1;
            if (w_last) begin
                r_d  <= w_shadow;
                r_bo <= w_bout;
                r_ov <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_shadow[WIDTH-1] != r_a[WIDTH-1]);
            end
        end
    end

    assign BUSY = r_state != ST_IDLE;
    assign DONE = r_state == ST_DONE;
    assign D    = r_d;
    assign BO   = r_bo;
    assign OV   = r_ov;
endmodule

// File: tb/tb_fsu4_seq.sv
// tb_fsu4_seq: directed and random checks of fsu4_seq at WIDTH 4, 16 and 32.
module tb_fsu4_seq;
    logic CK = 1'b0;
    logic CD;
    always #5 CK = ~CK;

    int n_chk = 0;
    int n_fail = 0;

    logic        st4, bi4, busy4, done4, bo4, ov4;
    logic [3:0]  a4, b4, d4;
    logic        st16, bi16, busy16, done16, bo16, ov16;
    logic [15:0] a16, b16, d16;
    logic        st32, bi32, busy32, done32, bo32, ov32;
    logic [31:0] a32, b32, d32;

    fsu4_seq #(.WIDTH(4)) u_dut4 (
        .CK(CK), .CD(CD), .START(st4), .A(a4), .B(b4), .BI(bi4),
        .BUSY(busy4), .DONE(done4), .D(d4), .BO(bo4), .OV(ov4)
    );
    fsu4_seq #(.WIDTH(16)) u_dut16 (
        .CK(CK), .CD(CD), .START(st16), .A(a16), .B(b16), .BI(bi16),
        .BUSY(busy16), .DONE(done16), .D(d16), .BO(bo16), .OV(ov16)
    );
    fsu4_seq #(.WIDTH(32)) u_dut32 (
        .CK(CK), .CD(CD), .START(st32), .A(a32), .B(b32), .BI(bi32),
        .BUSY(busy32), .DONE(done32), .D(d32), .BO(bo32), .OV(ov32)
    );

    task automatic drive(input int w, input logic st, input logic [31:0] a, input logic [31:0] b, input logic bi);
        if (w == 4) begin
            st4 = st; a4 = a[3:0]; b4 = b[3:0]; bi4 = bi;
        end else if (w == 16) begin
            st16 = st; a16 = a[15:0]; b16 = b[15:0]; bi16 = bi;
        end else begin
            st32 = st; a32 = a; b32 = b; bi32 = bi;
        end
    endtask

    function automatic logic done_of(input int w);
        return (w == 4) ? done4 : (w == 16) ? done16 : done32;
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 4) ? busy4 : (w == 16) ? busy16 : busy32;
    endfunction

    function automatic logic [33:0] res_of(input int w);
        return (w == 4) ? {bo4, ov4, 28'd0, d4} : (w == 16) ? {bo16, ov16, 16'd0, d16} : {bo32, ov32, d32};
    endfunction

    // Launch one operation, scramble the inputs after the accepting edge, wait for DONE.
    task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic bi,
                         output int lat, output int nbusy);
        @(negedge CK);
        drive(w, 1'b1, a, b, bi);
        @(posedge CK);
        #1 drive(w, 1'b0, ~a, ~b, ~bi);
        lat = 0;
        nbusy = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CK);
            if (busy_of(w)) nbusy++;
            if (done_of(w)) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        CD = 1'b1;
        drive(4, 0, 0, 0, 0);
        drive(16, 0, 0, 0, 0);
        drive(32, 0, 0, 0, 0);
        repeat (2) @(negedge CK);
        n_chk++;
        if ({busy16, done16, d16, bo16, ov16} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset16 got busy=%b done=%b d=%h bo=%b ov=%b want all 0", busy16, done16, d16, bo16, ov16);
        end
        n_chk++;
        if ({busy4, done4, d4, bo4, ov4, busy32, done32, d32, bo32, ov32} !== 44'd0) begin
            n_fail++;
            $display("FAIL reset4_32 got d4=%h d32=%h busy4=%b busy32=%b want all 0", d4, d32, busy4, busy32);
        end
        CD = 1'b0;
    endtask

    task automatic test_vectors;
        logic [15:0] va [5] = '{16'h1234, 16'h0000, 16'h8000, 16'h7FFF, 16'h00FF};
        logic [15:0] vb [5] = '{16'h0234, 16'h0001, 16'h0001, 16'hFFFF, 16'h000F};
        logic [15:0] vd [5] = '{16'h1000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h00F0};
        logic        vbo[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        vov[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int lat, nb;
        for (int k = 0; k < 5; k++) begin
            do_op(16, {16'd0, va[k]}, {16'd0, vb[k]}, 1'b0, lat, nb);
            n_chk++;
            if (lat != 5 || nb != 5) begin
                n_fail++;
                $display("FAIL timing%0d got lat=%0d busy=%0d want lat=5 busy=5", k, lat, nb);
            end
            n_chk++;
            if ({d16, bo16, ov16} !== {vd[k], vbo[k], vov[k]}) begin
                n_fail++;
                $display("FAIL vec%0d got d=%h bo=%b ov=%b want d=%h bo=%b ov=%b", k, d16, bo16, ov16, vd[k], vbo[k], vov[k]);
            end
        end
        @(negedge CK);
        n_chk++;
        if (done16 !== 1'b0 || busy16 !== 1'b0 || d16 !== 16'h00F0) begin
            n_fail++;
            $display("FAIL done_pulse got done=%b busy=%b d=%h want 0 0 00f0", done16, busy16, d16);
        end
    endtask

    task automatic test_start_held;
        int lat;
        bit seen;
        @(negedge CK);
        drive(16, 1'b1, 32'h0005, 32'h0005, 1'b1);
        @(posedge CK);
        #1 drive(16, 1'b1, 32'h1111, 32'h2222, 1'b0);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CK);
            if (done16) begin lat = i; break; end
        end
        n_chk++;
        if (lat != 5 || d16 !== 16'hFFFF || bo16 !== 1'b1 || ov16 !== 1'b0) begin
            n_fail++;
            $display("FAIL held_first got lat=%0d d=%h bo=%b ov=%b want lat=5 d=ffff bo=1 ov=0", lat, d16, bo16, ov16);
        end
        @(negedge CK);
        n_chk++;
        if (busy16 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_gap got busy=%b want 0", busy16);
        end
        @(negedge CK);
        drive(16, 1'b0, 32'h0, 32'h0, 1'b0);
        n_chk++;
        if (busy16 !== 1'b1 || d16 !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL second_start got busy=%b d=%h want busy=1 d=ffff", busy16, d16);
        end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CK);
            if (done16) seen = 1;
        end
        n_chk++;
        if (!seen || d16 !== 16'hEEEF || bo16 !== 1'b1 || ov16 !== 1'b0) begin
            n_fail++;
            $display("FAIL held_second got seen=%b d=%h bo=%b ov=%b want 1 eeef 1 0", seen, d16, bo16, ov16);
        end
    endtask

    task automatic test_abort;
        int lat, nb;
        bit seen;
        @(negedge CK);
        drive(16, 1'b1, 32'h4321, 32'h1234, 1'b0);
        @(posedge CK);
        #1 drive(16, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge CK);
        @(negedge CK);
        CD = 1'b1;
        #1;
        n_chk++;
        if ({busy16, done16, d16, bo16, ov16} !== 20'd0) begin
            n_fail++;
            $display("FAIL abort_clear got busy=%b done=%b d=%h bo=%b ov=%b want all 0", busy16, done16, d16, bo16, ov16);
        end
        @(negedge CK);
        CD = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge CK);
            if (done16 || busy16) seen = 1;
        end
        n_chk++;
        if (seen) begin
            n_fail++;
            $display("FAIL abort_nodone got activity=1 want 0");
        end
        do_op(16, 32'h00FF, 32'h000F, 1'b0, lat, nb);
        n_chk++;
        if (lat != 5 || d16 !== 16'h00F0 || bo16 !== 1'b0 || ov16 !== 1'b0) begin
            n_fail++;
            $display("FAIL after_abort got lat=%0d d=%h bo=%b ov=%b want 5 00f0 0 0", lat, d16, bo16, ov16);
        end
    endtask

    task automatic test_random;
        int ws [3] = '{4, 16, 32};
        int lat, nb, w;
        logic [32:0] full, mask;
        logic [31:0] a, b, ed;
        logic bi, ebo, eov;
        for (int j = 0; j < 3; j++) begin
            w = ws[j];
            mask = (33'd1 << w) - 33'd1;
            for (int k = 0; k < 8; k++) begin
                a = $urandom & mask[31:0];
                b = $urandom & mask[31:0];
                bi = 1'($urandom_range(1));
                full = {1'b0, a} - {1'b0, b} - {32'd0, bi};
                ed = full[31:0] & mask[31:0];
                ebo = full[w];
                eov = (a[w-1] != b[w-1]) && (ed[w-1] != a[w-1]);
                do_op(w, a, b, bi, lat, nb);
                n_chk++;
                if (lat != w / 4 + 1 || res_of(w) !== {ebo, eov, ed}) begin
                    n_fail++;
                    $display("FAIL rand_w%0d got lat=%0d bo/ov/d=%h want lat=%0d %h (a=%h b=%h bi=%b)",
                             w, lat, res_of(w), w / 4 + 1, {ebo, eov, ed}, a, b, bi);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_start_held;
        test_abort;
        test_random;
        repeat (2) @(negedge CK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fsu4_seq.md
FSU4_SEQ -- requirements
Module: fsu4_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Derived constant NNIB = WIDTH/4, number of nibble steps per operation.
REQ-003 CK  input  1  rising-edge clock; the block's only clock.
REQ-004 CD  input  1  asynchronous active-high reset (clear); CD=1 forces reset state immediately, independent of CK.
REQ-005 START  input  1  request pulse; sampled on CK rising edge; accepted only in IDLE.
REQ-006 A  input  WIDTH  minuend; sampled with accepted START.
REQ-007 B  input  WIDTH  subtrahend; sampled with accepted START.
REQ-008 BI  input  1  borrow-in; sampled with accepted START.
REQ-009 BUSY  output  1  high while in RUN or DONE.
REQ-010 DONE  output  1  single-cycle pulse; D, BO and OV are valid while it is high.
REQ-011 D  output  WIDTH  difference A - B - BI, modulo 2^WIDTH.
REQ-012 BO  output  1  borrow-out; 1 when A < B + BI (unsigned).
REQ-013 OV  output  1  signed two's-complement overflow of the subtraction.

Function
REQ-014 States SHALL be IDLE, RUN and DONE.
REQ-015 IDLE to RUN on a CK edge with START=1; on that edge A, B and BI are latched, the nibble index is set to 0 and the borrow register is set to BI.
REQ-016 In RUN, each CK edge computes nibble i as A[4i+3:4i] + ~B[4i+3:4i] + ~borrow, i.e. a 4-bit add with carry-in equal to NOT borrow.
- The nibble result is written into a shadow result register.
- borrow is set to NOT carry-out.
- The index is incremented.
REQ-017 After NNIB RUN cycles (index reaching NNIB-1 is processed), the shadow register is copied to D, the final borrow to BO and the computed overflow to OV; state moves to DONE on the same edge.
REQ-018 DONE SHALL last exactly one cycle (DONE=1) and then return to IDLE.
REQ-019 Latency: with START sampled at edge t0, DONE is high in the cycle following edge t0+NNIB. For WIDTH=16 that is 4 RUN edges, DONE after edge t0+4.
REQ-020 D, BO and OV update only on the commit edge of REQ-017 and hold between operations; partial nibbles SHALL never appear on D.
REQ-021 OV = (A[WIDTH-1] != B[WIDTH-1]) AND (D[WIDTH-1] != A[WIDTH-1]), using the latched operands.
REQ-022 START while BUSY=1, including in the DONE cycle, SHALL be ignored and SHALL NOT alter the latched operands.
REQ-023 A new START accepted in IDLE directly after DONE gives back-to-back operations with one idle gap cycle.
REQ-024 Changes on A, B or BI after the accepting edge SHALL NOT affect the result in progress.

Reset
REQ-025 While CD=1: state is IDLE, BUSY=0, DONE=0, D=0, BO=0, OV=0, and the index, borrow, latched operands and shadow register are all 0.
REQ-026 CD asserted mid-RUN or in DONE SHALL abort the operation with no DONE pulse. After CD is released, the first accepted START begins a fresh operation.

Structure
REQ-027 Package fsu4_pkg SHALL hold the state enumeration (IDLE, RUN, DONE), the nibble width constant 4, and the default WIDTH.
REQ-028 Sub-module fsu4_slice SHALL be the purely combinational 4-bit slice. Inputs: X[3:0], Y[3:0], BIN. Outputs: DIFF[3:0], BOUT. It is instantiated once in fsu4_seq and reused on every RUN cycle.

Verification
REQ-029 WIDTH=16, A=0x1234, B=0x0234, BI=0 -> D=0x1000, BO=0, OV=0. DONE after edge t0+4, BUSY high for 5 cycles.
REQ-030 A=0x0000, B=0x0001, BI=0 -> D=0xFFFF, BO=1, OV=0.
REQ-031 A=0x8000, B=0x0001, BI=0 -> D=0x7FFF, BO=0, OV=1. A=0x7FFF, B=0xFFFF -> D=0x8000, BO=1, OV=1.
REQ-032 A=0x0005, B=0x0005, BI=1 -> D=0xFFFF, BO=1. Then START held high with new operands during RUN and DONE -> first result unaffected; second operation starts only after the IDLE cycle.
REQ-033 CD pulsed on the 2nd RUN cycle -> no DONE pulse; D, BO, OV, BUSY read 0. The next START with A=0x00FF, B=0x000F -> D=0x00F0, BO=0.
REQ-034 Random-operand regression against a reference model of (A - B - BI) mod 2^WIDTH, for WIDTH = 4, 16 and 32.
